// File: rtl/linreg_mac_sequencer.sv
// Sequential linear-regression evaluator: price = c0 + sum(ck * xk).
// One shared 16x16 multiplier and a split 32-bit adder process one feature per beat.
module linreg_mac_sequencer #(
  parameter int N_FEAT = 3,
  parameter int AW     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [15:0]   cfg_data,
  input  logic          start,
  output logic          busy,
  input  logic [15:0]   x_data,
  input  logic          x_valid,
  output logic          x_ready,
  output logic [31:0]   price,
  output logic          rout,
  output logic          out_valid,
  input  logic          out_ready
);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  localparam int            NREG = 1 << AW;
  localparam logic [AW-1:0] LAST = AW'(N_FEAT);

  state_t        state, state_nx;
  logic [15:0]   coef [NREG];
  logic [AW-1:0] idx;
  logic [31:0]   acc;
  logic [31:0]   product;
  logic [16:0]   sum_lo;
  logic [16:0]   sum_hi;
  logic          beat;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx  = state;
    x_ready   = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    beat      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = MAC;
      end
      MAC: begin
        busy    = 1'b1;
        x_ready = 1'b1;
        beat    = x_valid;
        if (x_valid && idx == LAST) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Entries above N_FEAT are never written and read back as zero.
  assign product = {16'h0000, coef[idx]} * {16'h0000, x_data};
  assign sum_lo  = {1'b0, acc[15:0]} + {1'b0, product[15:0]};
  assign sum_hi  = {1'b0, acc[31:16]} + {1'b0, product[31:16]} + {16'h0000, sum_lo[16]};

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      rout  <= 1'b0;
      idx   <= AW'(1);
      // NOTE: the coefficient file is reset explicitly because a fresh run must see zeros.
      for (int i = 0; i < NREG; i++) coef[i] <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        acc  <= {16'h0000, coef[0]};
        idx  <= AW'(1);
        rout <= 1'b0;
      end
      if (beat) begin
        acc  <= {sum_hi[15:0], sum_lo[15:0]};
        rout <= rout | sum_hi[16];
        idx  <= idx + 1'b1;
      end
      // A write alongside start lands after the run has already latched c0.
      if (cfg_we && state == IDLE && cfg_addr <= LAST) coef[cfg_addr] <= cfg_data;
    end
  end

  assign price = acc;

endmodule

// File: tb/tb_linreg_mac_sequencer.sv
// Scoreboard bench for linreg_mac_sequencer: expected results queued at start,
// compared when the result handshake completes.
module tb_linreg_mac_sequencer;

  localparam int N_FEAT = 3;
  localparam int AW     = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [15:0]   cfg_data = '0;
  logic          start = 1'b0;
  logic          busy;
  logic [15:0]   x_data = '0;
  logic          x_valid = 1'b0;
  logic          x_ready;
  logic [31:0]   price;
  logic          rout;
  logic          out_valid;
  logic          out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [15:0] mc [N_FEAT+1];
  logic [32:0] sb [$];

  always #5 clk = ~clk;

  linreg_mac_sequencer #(.N_FEAT(N_FEAT), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .busy(busy), .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .price(price), .rout(rout), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 33-bit accumulation with a sticky bit-32 carry.
  function automatic logic [32:0] model(input logic [15:0] x0, x1, x2);
    logic [15:0] xs [3];
    logic [31:0] a;
    logic [32:0] s;
    logic        r;
    xs[0] = x0; xs[1] = x1; xs[2] = x2;
    a = {16'h0000, mc[0]};
    r = 1'b0;
    for (int i = 0; i < N_FEAT; i++) begin
      s = {1'b0, a} + 33'(32'(mc[i+1]) * 32'(xs[i]));
      a = s[31:0];
      r = r | s[32];
    end
    return {r, a};
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("sb_nonempty", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        logic [32:0] e;
        e = sb.pop_front();
        check("price", price, e[31:0]);
        check("rout", rout, e[32]);
      end
    end
  end

  task automatic cfg_write(input logic [AW-1:0] addr, input logic [15:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
    step;
    cfg_we = 1'b0;
    if (addr <= N_FEAT) mc[addr] = data;
  endtask

  task automatic run(input logic [15:0] x0, x1, x2, input int gap, input int hold,
                     input bit guard, input bit cfg_at_start, input logic [15:0] c0_new,
                     input string tag);
    logic [15:0] xs [3];
    logic [31:0] snap_p;
    logic        snap_r;
    int          cyc;
    xs[0] = x0; xs[1] = x1; xs[2] = x2;
    sb.push_back(model(x0, x1, x2));
    start = 1'b1;
    if (cfg_at_start) begin cfg_we = 1'b1; cfg_addr = '0; cfg_data = c0_new; end
    step;
    start = 1'b0; cfg_we = 1'b0;
    if (cfg_at_start) mc[0] = c0_new;
    cyc = 1;
    check({tag, "_xready"}, x_ready, 1);
    for (int i = 0; i < N_FEAT; i++) begin
      x_valid = 1'b0;
      snap_p = price;
      for (int g = 0; g < gap; g++) begin
        step; cyc++;
        check({tag, "_gap_hold"}, price, snap_p);
      end
      x_valid = 1'b1; x_data = xs[i];
      if (guard && i == 1) begin cfg_we = 1'b1; cfg_addr = 1; cfg_data = 16'h0001; end
      step; cyc++;
      cfg_we = 1'b0;
    end
    x_valid = 1'b0;
    for (int w = 0; w < 20 && !out_valid; w++) begin step; cyc++; end
    check({tag, "_out_valid"}, out_valid, 1);
    if (gap == 0) check({tag, "_latency"}, cyc, N_FEAT + 1);
    snap_p = price; snap_r = rout;
    for (int h = 0; h < hold; h++) begin
      if (guard && h == 0) start = 1'b1;
      step;
      start = 1'b0;
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_price"}, price, snap_p);
      check({tag, "_hold_rout"}, rout, snap_r);
    end
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_xready"}, x_ready, 0);
  endtask

  task automatic load_nominal;
    cfg_write(0, 16'h0000);
    cfg_write(1, 16'h02CD);
    cfg_write(2, 16'h8FD8);
    cfg_write(3, 16'hFDE8);
  endtask

  initial begin
    for (int i = 0; i <= N_FEAT; i++) mc[i] = '0;
    step; step;
    check("rst_busy", busy, 0);
    check("rst_xready", x_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_price", price, 0);
    check("rst_rout", rout, 0);
    rst_n = 1'b1;
    step;

    load_nominal();
    run(16'd100, 16'd4, 16'd1, 0, 0, 1'b0, 1'b0, 16'h0, "nominal");
    step;
    run(16'd100, 16'd4, 16'd1, 3, 5, 1'b0, 1'b0, 16'h0, "backpressure");
    step;
    run(16'd100, 16'd4, 16'd1, 0, 2, 1'b1, 1'b0, 16'h0, "guard");
    step;
    run(16'd100, 16'd4, 16'd1, 0, 0, 1'b0, 1'b0, 16'h0, "rerun");
    step;

    cfg_write(AW'(N_FEAT + 1), 16'hFFFF);
    run(16'd100, 16'd4, 16'd1, 0, 0, 1'b0, 1'b0, 16'h0, "cfg_oob");
    step;
    run(16'd100, 16'd4, 16'd1, 0, 0, 1'b0, 1'b1, 16'h1234, "cfg_at_start");
    step;
    run(16'd100, 16'd4, 16'd1, 0, 0, 1'b0, 1'b0, 16'h0, "cfg_after");
    step;

    cfg_write(0, 16'hFFFF);
    cfg_write(1, 16'hFFFF);
    cfg_write(2, 16'hFFFF);
    cfg_write(3, 16'h0000);
    run(16'hFFFF, 16'hFFFF, 16'h0000, 0, 1, 1'b0, 1'b0, 16'h0, "carry");
    step;

    load_nominal();
    start = 1'b1; step; start = 1'b0;
    x_valid = 1'b1; x_data = 16'd100; step;
    x_data = 16'd4; step;
    x_valid = 1'b0;
    rst_n = 1'b0; step;
    check("midrst_busy", busy, 0);
    check("midrst_xready", x_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_price", price, 0);
    check("midrst_rout", rout, 0);
    rst_n = 1'b1;
    for (int i = 0; i <= N_FEAT; i++) mc[i] = '0;
    step;
    run(16'd5, 16'd5, 16'd5, 0, 0, 1'b0, 1'b0, 16'h0, "post_rst");
    step;

    check("sb_drained", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
